// File: rtl/sad_pkg.sv
// Shared types and sizing for the SAD block sequencer and its lane-sum datapath.
package sad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_LANES = 8;
  localparam int DEF_PIX_W = 8;
  localparam int DEF_BEATS = 8;

  // Accumulator width large enough that a full block of max differences cannot overflow.
  function automatic int acc_width(input int lanes, input int pix_w, input int beats);
    return pix_w + $clog2(lanes * beats);
  endfunction

endpackage

// File: rtl/sad_lane_sum.sv
// Combinational per-beat SAD: eight absolute differences reduced by a 3:2 compressor tree.
module sad_lane_sum
  import sad_pkg::*;
#(
  parameter  int LANES = DEF_LANES,
  parameter  int PIX_W = DEF_PIX_W,
  localparam int SUM_W = PIX_W + $clog2(LANES)
) (
  input  logic [LANES*PIX_W-1:0] i_cur_pix,
  input  logic [LANES*PIX_W-1:0] i_ref_pix,
  output logic [SUM_W-1:0]       o_lane_sum
);

  logic [SUM_W-1:0] w_diff [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_abs
    logic [PIX_W-1:0] w_c;
    logic [PIX_W-1:0] w_r;
    logic [PIX_W-1:0] w_abs;
    assign w_c       = i_cur_pix[g*PIX_W +: PIX_W];
    assign w_r       = i_ref_pix[g*PIX_W +: PIX_W];
    assign w_abs     = (w_c >= w_r) ? (w_c - w_r) : (w_r - w_c);
    assign w_diff[g] = {{(SUM_W-PIX_W){1'b0}}, w_abs};
  end

  // Carry bits shifted out of SUM_W are safe to drop: the true total always fits.
  function automatic logic [2*SUM_W-1:0] csa(input logic [SUM_W-1:0] a,
                                             input logic [SUM_W-1:0] b,
                                             input logic [SUM_W-1:0] c);
    logic [SUM_W-1:0] s;
    logic [SUM_W-1:0] cy;
    s  = a ^ b ^ c;
    cy = ((a & b) | (a & c) | (b & c)) << 1;
    return {cy, s};
  endfunction

  logic [SUM_W-1:0] w_s0, w_c0, w_s1, w_c1, w_s2, w_c2;
  logic [SUM_W-1:0] w_s3, w_c3, w_s4, w_c4, w_s5, w_c5;

  assign {w_c0, w_s0} = csa(w_diff[0], w_diff[1], w_diff[2]);
  assign {w_c1, w_s1} = csa(w_diff[3], w_diff[4], w_diff[5]);
  assign {w_c2, w_s2} = csa(w_s0, w_c0, w_s1);
  assign {w_c3, w_s3} = csa(w_c1, w_diff[6], w_diff[7]);
  assign {w_c4, w_s4} = csa(w_s2, w_c2, w_s3);
  assign {w_c5, w_s5} = csa(w_s4, w_c4, w_c3);

  assign o_lane_sum = w_s5 + w_c5;

endmodule

// File: rtl/sad_block_ctrl.sv
// Frames BEATS pixel beats into one block, accumulates lane sums and hands the SAD downstream.
module sad_block_ctrl
  import sad_pkg::*;
#(
  parameter  int LANES = DEF_LANES,
  parameter  int PIX_W = DEF_PIX_W,
  parameter  int BEATS = DEF_BEATS,
  localparam int ACC_W = acc_width(LANES, PIX_W, BEATS),
  localparam int CNT_W = $clog2(BEATS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*PIX_W-1:0] cur_pix,
  input  logic [LANES*PIX_W-1:0] ref_pix,
  output logic                   sad_valid,
  input  logic                   sad_ready,
  output logic [ACC_W-1:0]       sad_out,
  output logic                   busy,
  output logic [CNT_W-1:0]       beat_cnt
);

  localparam int LS_W = PIX_W + $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_sad_out;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [LS_W-1:0]  w_lane_sum;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_accept;
  logic             w_last;

  sad_lane_sum #(.LANES(LANES), .PIX_W(PIX_W)) u_lane_sum (
    .i_cur_pix  (cur_pix),
    .i_ref_pix  (ref_pix),
    .o_lane_sum (w_lane_sum)
  );

  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_beat_cnt == LAST_BEAT);
  assign w_acc_next = r_acc + {{(ACC_W-LS_W){1'b0}}, w_lane_sum};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = ACCUM;
      ACCUM:   if (w_accept && w_last) w_next_state = DONE;
      DONE:    if (sad_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ACCUM);
    sad_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  // Result register is only written on the final beat, so it holds through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_beat_cnt <= '0;
      r_sad_out  <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_acc      <= '0;
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_acc <= w_acc_next;
        if (w_last) begin
          r_sad_out  <= w_acc_next;
          r_beat_cnt <= '0;
        end else begin
          r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign sad_out  = r_sad_out;
  assign beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_sad_block_ctrl.sv
// Directed self-checking bench for sad_block_ctrl with hand-computed block SADs.
module tb_sad_block_ctrl;

  localparam int LANES = 8;
  localparam int PIX_W = 8;
  localparam int BEATS = 8;
  localparam int ACC_W = PIX_W + $clog2(LANES * BEATS);
  localparam int CNT_W = $clog2(BEATS);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*PIX_W-1:0] cur_pix;
  logic [LANES*PIX_W-1:0] ref_pix;
  logic                   sad_valid;
  logic                   sad_ready;
  logic [ACC_W-1:0]       sad_out;
  logic                   busy;
  logic [CNT_W-1:0]       beat_cnt;

  int errors = 0;
  int checks = 0;

  sad_block_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cur_pix   (cur_pix),
    .ref_pix   (ref_pix),
    .sad_valid (sad_valid),
    .sad_ready (sad_ready),
    .sad_out   (sad_out),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] splat(input logic [7:0] v);
    return {8{v}};
  endfunction

  // One beat, optionally preceded by a random idle cycle on in_valid.
  task automatic applyStimulus(input logic [63:0] c, input logic [63:0] r, input bit stall);
    if (stall && $urandom_range(0, 1) == 1) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    cur_pix  = c;
    ref_pix  = r;
    in_valid = 1'b1;
    checkOutput("in_ready_accum", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic startBlock();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("cnt_at_start", beat_cnt, 0);
    checkOutput("valid_in_accum", sad_valid, 0);
  endtask

  // Expects DONE right now, holds sad_ready low, then handshakes.
  task automatic finishBlock(input logic [31:0] exp, input int hold, input bit pokeStart);
    checkOutput("sad_valid_latency", sad_valid, 1);
    checkOutput("sad_out", sad_out, exp);
    checkOutput("cnt_wrapped", beat_cnt, 0);
    for (int k = 0; k < hold; k++) begin
      sad_ready = 1'b0;
      start     = pokeStart;
      @(negedge clk);
      checkOutput("sad_hold", sad_out, exp);
      checkOutput("valid_hold", sad_valid, 1);
      checkOutput("in_ready_done", in_ready, 0);
    end
    sad_ready = 1'b1;
    start     = pokeStart;
    @(negedge clk);
    sad_ready = 1'b0;
    start     = 1'b0;
    checkOutput("valid_cleared", sad_valid, 0);
    checkOutput("busy_idle", busy, 0);
    checkOutput("sad_kept_idle", sad_out, exp);
    if (pokeStart) begin
      @(negedge clk);
      checkOutput("no_extra_block", busy, 0);
    end
  endtask

  initial begin
    logic [63:0] cv;
    logic [63:0] rv;
    int          gold;
    int          c;
    int          r;

    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    sad_ready = 1'b0;
    cur_pix   = '0;
    ref_pix   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", sad_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_sad_out", sad_out, 0);
    checkOutput("rst_cnt", beat_cnt, 0);

    // Basic block: |10-3| * 8 lanes * 8 beats = 448.
    startBlock();
    for (int b = 0; b < BEATS; b++) begin
      applyStimulus(splat(8'd10), splat(8'd3), 1'b0);
      if (b == 3) checkOutput("cnt_mid", beat_cnt, 4);
    end
    finishBlock(448, 0, 1'b0);

    // Worst case and its mirror: 255 * 64 = 16320 either way.
    startBlock();
    for (int b = 0; b < BEATS; b++) applyStimulus(splat(8'd255), splat(8'd0), 1'b0);
    finishBlock(16320, 0, 1'b0);
    startBlock();
    for (int b = 0; b < BEATS; b++) applyStimulus(splat(8'd0), splat(8'd255), 1'b0);
    finishBlock(16320, 0, 1'b0);

    // Mixed lanes with random stalls and a held-off result.
    gold = 0;
    startBlock();
    for (int b = 0; b < BEATS; b++) begin
      for (int i = 0; i < LANES; i++) begin
        c = (i * 30 + b * 7) & 255;
        r = (255 - i * 20 - b * 3) & 255;
        cv[i*8 +: 8] = 8'(c);
        rv[i*8 +: 8] = 8'(r);
        gold += (c > r) ? (c - r) : (r - c);
      end
      applyStimulus(cv, rv, 1'b1);
    end
    finishBlock(32'(gold), 5, 1'b0);

    // start ignored in ACCUM and DONE; in_valid ignored in IDLE. |2-5|*64 = 192.
    in_valid = 1'b1;
    cur_pix  = splat(8'd50);
    ref_pix  = splat(8'd0);
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("idle_no_accept_cnt", beat_cnt, 0);
    checkOutput("idle_no_accept_busy", busy, 0);
    startBlock();
    for (int b = 0; b < BEATS; b++) begin
      start = (b == 3);
      applyStimulus(splat(8'd2), splat(8'd5), 1'b0);
      start = 1'b0;
    end
    finishBlock(192, 2, 1'b1);

    // Abort mid-block, then a clean block of 64.
    startBlock();
    for (int b = 0; b < 4; b++) applyStimulus(splat(8'd200), splat(8'd0), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_valid", sad_valid, 0);
    checkOutput("abort_in_ready", in_ready, 0);
    checkOutput("abort_cnt", beat_cnt, 0);
    checkOutput("abort_sad_out", sad_out, 0);
    startBlock();
    for (int b = 0; b < BEATS; b++) applyStimulus(splat(8'd1), splat(8'd0), 1'b0);
    finishBlock(64, 0, 1'b0);

    // Back-to-back: start on the cycle right after the handshake. |4-9|*64 = 320.
    startBlock();
    for (int b = 0; b < BEATS; b++) applyStimulus(splat(8'd4), splat(8'd9), 1'b0);
    finishBlock(320, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sad_block_ctrl.md
Name: sad_block_ctrl

Overview:
- Sequencer/accumulator for sum-of-absolute-difference (SAD) over one pixel block.
- Each accepted beat carries LANES current/reference pixel pairs. A combinational lane-sum sub-module computes the lane absolute differences and reduces them through the team's compressor tree.
- This block frames BEATS beats into one block, accumulates the lane sums, and hands the final SAD downstream over a valid/ready handshake.
- It sits between the pixel fetch unit and the motion-estimation compare logic.

Parameters:
- LANES, 8, pixel pairs per beat; must be 8 to match the 8-input compressor tree.
- PIX_W, 8, bits per pixel.
- BEATS, 8, beats per block (8x8 block by default); allowed range 2..256.
- ACC_W, PIX_W+$clog2(LANES*BEATS), accumulator/result width; derived, never overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  one-cycle request to begin a block; honoured only in IDLE.
- in_valid  in  1  pixel beat valid.
- in_ready  out  1  block accepts a beat.
- cur_pix  in  LANES*PIX_W  current pixels; lane i at bits [i*PIX_W +: PIX_W].
- ref_pix  in  LANES*PIX_W  reference pixels; same packing as cur_pix.
- sad_valid  out  1  result valid.
- sad_ready  in  1  downstream accepts the result.
- sad_out  out  ACC_W  block SAD.
- busy  out  1  high in ACCUM or DONE.
- beat_cnt  out  $clog2(BEATS)  beats accepted so far in the current block.

Interface (already decided):
- One clock: clk.
- Reset rst is synchronous and active-high.

Behaviour:
- FSM states: IDLE, ACCUM, DONE.
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE.
  - acc, beat_cnt, sad_out, sad_valid, in_ready and busy all go to 0.
  - Applies from any state, mid-block included. Partial sums are discarded; no result is emitted.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start=1 -> ACCUM next cycle, with acc=0 and beat_cnt=0.
  - sad_out holds the previous result, but sad_valid=0.
- ACCUM:
  - in_ready=1 combinationally from state.
  - A beat is accepted when in_valid && in_ready. On acceptance: acc <= acc + lane_sum and beat_cnt increments.
  - Cycles with in_valid=0 are stalls; nothing changes.
  - On the last beat (beat_cnt==BEATS-1 and accepted):
    - sad_out <= acc + lane_sum; sad_valid <= 1; state -> DONE.
    - beat_cnt wraps to 0.
  - start is ignored in ACCUM.
- DONE:
  - in_ready=0; sad_valid=1.
  - sad_out is stable until the handshake.
  - sad_valid && sad_ready -> sad_valid <= 0; state -> IDLE.
  - start in DONE is ignored, including on the handshake cycle. A new block requires start in IDLE.
- Latency: sad_valid rises on the cycle after the final beat is accepted. With no stalls, that is BEATS+1 cycles after the cycle in which start is sampled.
- Arithmetic:
  - lane_sum = sum over lanes of |cur-ref|, unsigned, width PIX_W+$clog2(LANES).
  - Zero-extend lane_sum to ACC_W before adding.
  - ACC_W is sized so overflow is impossible; no saturation logic.
  - Worst case with defaults: 64*255 = 16320, which fits in 14 bits.
- busy = (state != IDLE).

Decomposition:
- Package sad_pkg holds:
  - FSM state enum (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2).
  - Default LANES/PIX_W/BEATS constants.
  - The ACC_W derivation function.
- Sub-module sad_lane_sum (combinational): LANES absolute-difference units feeding the 8-input compressor tree plus a final carry-propagate adder, producing lane_sum.
- Controller and accumulator stay in sad_block_ctrl.

Test Plan:
1. Reset, then start, then 8 beats with all cur=10 and all ref=3 -> lane_sum=56. One cycle after beat 8: sad_valid=1, sad_out=448. sad_ready=1 -> IDLE, busy=0.
2. Worst case: cur=255, ref=0 for all lanes and beats -> sad_out=16320, no overflow. Swap cur/ref -> same result (abs symmetry).
3. Random in_valid stalls (about 50%) and sad_ready held low 5 cycles:
   - sad_out equals the golden model.
   - sad_out is stable while sad_valid=1 && sad_ready=0.
   - in_ready=0 throughout DONE.
4. start pulsed during ACCUM and during DONE -> ignored: no acc clear, no extra block. in_valid pulsed in IDLE -> nothing accepted.
5. rst=1 after beat 4 -> next cycle state IDLE, all outputs 0. A new start plus 8 beats of cur=1, ref=0 -> sad_out=64, with no contamination from the aborted block.
6. Back-to-back blocks: handshake, then start on the next cycle -> second block's SAD is correct and beat_cnt restarts at 0.
